// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot channel decoder with a prescaled scan mode.
//
// Operating mode is chosen every cycle from En/mode:
//   IDLE   (En=0)         outputs inactive, idx held, load ignored
//   DIRECT (En=1,mode=0)  load captures A into idx
//   SCAN   (En=1,mode=1)  idx advances to the next enabled channel every
//                         PRESCALE cycles; load restarts the count from A
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   En, mode       enable / mode select (0 DIRECT, 1 SCAN)
//   A, load        channel to capture and its single-cycle strobe
//   mask           (DECODER_SCAN_MASK_EN only) bit i=1 disables channel i
//   out            registered one-hot decode of idx (inverted if ACTIVE_LOW)
//   idx            current channel index
//   step, wrap     one-cycle pulses on scan advance / advance to a lower index
//
// Build option: define DECODER_SCAN_MASK_EN to add the channel mask port.
module decoder_scan #(
  parameter int SEL_W      = 4,
  parameter int PRESCALE   = 100000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    En,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        A,
  input  logic                    load,
`ifdef DECODER_SCAN_MASK_EN
  input  logic [(2**SEL_W)-1:0]   mask,
`endif
  output logic [(2**SEL_W)-1:0]   out,
  output logic [SEL_W-1:0]        idx,
  output logic                    step,
  output logic                    wrap
);

  localparam int OUT_W = 2**SEL_W;
  localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PSC_LAST = PW'(PRESCALE - 1);
  localparam logic [OUT_W-1:0] OUT_OFF  = {OUT_W{ACTIVE_LOW != 0}};

  typedef enum logic [1:0] {S_IDLE, S_DIRECT, S_SCAN} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [PW-1:0]      psc_q, psc_d;
  logic               step_q, step_d;
  logic               wrap_q, wrap_d;
  logic [OUT_W-1:0]   out_q, out_d;

  // Channel enable vector
  logic [OUT_W-1:0] en_ch;
`ifdef DECODER_SCAN_MASK_EN
  assign en_ch = ~mask;
`else
  assign en_ch = '1;
`endif

  // Next enabled channel after idx_q, searched circularly. Walking k from
  // the far end down lets the nearest hit overwrite the others. k=OUT_W
  // lands back on idx_q, so a single enabled channel re-selects itself.
  logic [SEL_W-1:0] nxt_idx, cand;
  logic             nxt_ok;
  always_comb begin
    nxt_idx = idx_q;
    nxt_ok  = 1'b0;
    cand    = '0;
    for (int k = OUT_W; k >= 1; k--) begin
      cand = idx_q + SEL_W'(k);
      if (en_ch[cand]) begin
        nxt_idx = cand;
        nxt_ok  = 1'b1;
      end
    end
  end

  // Next state follows the inputs directly every cycle
  always_comb begin
    state_d = S_IDLE;
    if (En) state_d = mode ? S_SCAN : S_DIRECT;
  end

  // Datapath acts on this cycle's mode decision so load/advance take effect
  // on the same edge as the mode change; state_q only marks scan entry.
  always_comb begin
    idx_d  = idx_q;
    psc_d  = '0;
    step_d = 1'b0;
    wrap_d = 1'b0;
    unique case (state_d)
      S_DIRECT: if (load) idx_d = A;
      S_SCAN: begin
        if (load) begin
          idx_d = A;              // load beats a coincident terminal count
        end else if (state_q != S_SCAN) begin
          psc_d = '0;             // fresh entry: full PRESCALE before first step
        end else if (psc_q == PSC_LAST) begin
          if (nxt_ok) begin
            idx_d  = nxt_idx;
            step_d = 1'b1;
            wrap_d = (nxt_idx < idx_q);
          end
        end else begin
          psc_d = psc_q + 1'b1;
        end
      end
      default: ;
    endcase

    out_d = OUT_OFF;
    if (state_d != S_IDLE && en_ch[idx_d])
      out_d = (OUT_W'(1) << idx_d) ^ OUT_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      psc_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      out_q   <= OUT_OFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      psc_q   <= psc_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      out_q   <= out_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule
